dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Parametrised data memory for the pipeline's MEM stage, successor to the single-port word memory. Adds byte/halfword/word loads and stores with sign or zero extension, a registered one-cycle read with explicit valid, misalignment detection, and an optional post-reset clear sequencer. Sits between the EX/MEM pipeline register and the MEM/WB register. The pipeline stalls on `ready` low.

## Interface
Parameters:
- `DEPTH`, 64: number of 32-bit words; power of two, ≥ 2.
- `ADDR_WIDTH`, 32: byte-address width.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in 1: access request, sampled when `ready` = 1.
- `write` in 1: 1 = store, 0 = load.
- `size` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `unsigned_ld` in 1: 1 = zero-extend loads, 0 = sign-extend.
- `address` in ADDR_WIDTH: byte address.
- `write_data` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `ready` out 1: accepting requests.
- `read_valid` out 1: `read_data` valid this cycle.
- `read_data` out 32: extended load result.
- `misaligned` out 1: error pulse for the previous accepted request.

## Operation
- Word index = `address[2 +: log2(DEPTH)]`. Upper address bits are ignored, so addresses wrap modulo 4·DEPTH.
- Byte lane = `address[1:0]`. A byte store writes only that lane. A half store writes lanes {1,0} or {3,2} per `address[1]`. A word store writes all four lanes.
- A load selects the same lanes, shifts them to bit 0, then sign- or zero-extends to 32 bits. Word loads ignore `unsigned_ld`.
- Misalignment occurs on a half with `address[0]`=1, a word with `address[1:0]`≠0, or any `size`=11. On misalignment:
  - No memory write occurs.
  - `read_valid` stays 0.
  - `read_data` holds its previous value.
  - `misaligned` pulses.
- Requests while `ready`=0 are ignored entirely, with no side effects.
- FSM:
  - S_INIT: `ready`=0. The clear counter runs as described under Configuration.
  - S_IDLE: `ready`=1. Stays in S_IDLE until reset.
- Reset asserted in any state, including mid-clear, forces S_INIT and the counter to 0. The clear restarts from word 0.

## Timing
- Reset values: `ready`=0, `read_valid`=0, `read_data`=0, `misaligned`=0, state S_INIT, clear counter 0.
- Store accepted at edge N: memory updated at edge N. A load accepted at edge N+1 to the same word returns the new data.
- Load accepted at edge N: `read_data` and `read_valid`=1 are registered and visible after edge N. They are held for exactly one cycle. `read_valid` returns to 0 after edge N+1 unless another load is accepted at that edge.
- `read_data` holds its last loaded value when `read_valid`=0.
- `misaligned` is registered: it is 1 for the one cycle after the offending edge, otherwise 0.
- Back-to-back accepted requests, one per cycle, are supported with no bubbles.

## Configuration
- `DMEM_CLEAR_EN` defined:
  - S_INIT writes 0 to word `counter` each cycle and increments the counter.
  - At the edge where `counter`=DEPTH−1, the FSM moves to S_IDLE.
  - `ready` rises after DEPTH rising edges following reset release.
- `DMEM_CLEAR_EN` undefined:
  - No clear counter is built.
  - S_INIT moves to S_IDLE at the first rising edge after reset release, so `ready`=1 after one edge.
  - Memory contents are uninitialised (X in simulation).

## Structure
- Package `dmem_pkg` holds:
  - `size` encodings: SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD.
  - State enum: S_INIT, S_IDLE.
  - Helper constant for the lane-select width.
- Sub-module `dmem_load_align` is combinational. It takes the 32-bit word, `address[1:0]`, `size` and `unsigned_ld`, and produces the extended result plus the misalign flag. It is instantiated once.
- Store lane merge, the FSM, the counter and the storage array live in `dmem_ctrl`.

## Test plan
- Clear and ready:
  - With `DMEM_CLEAR_EN` and DEPTH=64, release reset; `ready` must rise exactly after 64 edges.
  - Then load word at address 20 → `read_valid`=1 next cycle, `read_data`=0.
- Word store then load: store 0xDEADBEEF at address 12, then load word at 12 on the next cycle → `read_data`=0xDEADBEEF.
- Byte and half loads:
  - With word 12 = 0xDEADBEEF, load byte at 13 signed → 0xFFFFFFBE.
  - Load byte at 13 unsigned → 0x000000BE.
  - Load half at 14 signed → 0xFFFFDEAD.
- Partial stores:
  - Store byte 0x11 at 12, then half 0x2233 at 14, then load word at 12 → 0x2233BE11.
- Misalignment:
  - Store word at address 14 → `misaligned`=1 for one cycle; word 12 unchanged.
  - Load half at 13 → `misaligned`=1, `read_valid`=0.
- Reset mid-clear: assert `reset_n`=0 at edge 30 of the clear, then release; `ready` must rise after 64 more edges; word 0 through word 63 all read 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the MEM-stage data memory: access sizes, controller states, lane width.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic {
        S_INIT = 1'b0,
        S_IDLE = 1'b1
    } state_e;

    // Byte-lane select is address[1:0] within a 32-bit word
    localparam int LANE_W = 2;

endpackage

// File: rtl/dmem_if.sv
// Request/response bundle between the EX/MEM register, the data memory and the MEM/WB register.
interface dmem_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req;
    logic                  write;
    logic [1:0]            size;
    logic                  unsigned_ld;
    logic [ADDR_WIDTH-1:0] address;
    logic [31:0]           write_data;
    logic                  ready;
    logic                  read_valid;
    logic [31:0]           read_data;
    logic                  misaligned;

    modport master (
        output req, write, size, unsigned_ld, address, write_data,
        input  ready, read_valid, read_data, misaligned
    );

    modport slave (
        input  req, write, size, unsigned_ld, address, write_data,
        output ready, read_valid, read_data, misaligned
    );
endinterface

// File: rtl/dmem_load_align.sv
// Lane select + sign/zero extension of a load, and alignment check shared with stores.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle regardless of acceptance.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0]       rd_word,
    input  logic [LANE_W-1:0] lane,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    output logic [31:0]       result,
    output logic              misaligned
);
    logic [31:0] shifted;

    assign shifted = rd_word >> {lane, 3'b000};

    always_comb begin
        result     = '0;
        misaligned = 1'b0;
        case (size_e'(size))
            SZ_BYTE: result = {{24{~unsigned_ld & shifted[7]}}, shifted[7:0]};
            SZ_HALF: begin
                misaligned = lane[0];
                result     = {{16{~unsigned_ld & shifted[15]}}, shifted[15:0]};
            end
            SZ_WORD: begin
                misaligned = (lane != '0);
                result     = rd_word;
            end
            default: misaligned = 1'b1;
        endcase
    end
endmodule

// File: rtl/dmem_ctrl.sv
// Byte/half/word data memory for the MEM stage; DMEM_CLEAR_EN adds a post-reset zero-fill.
// Latency: stores commit at the accepting edge; load data and read_valid are registered, one cycle.
// Backpressure: ready low while initialising; requests seen with ready low are dropped.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic clk,
    input  logic reset_n,
    dmem_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [31:0]       mem [DEPTH];
    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx;
    logic [LANE_W-1:0] lane;
    logic [31:0]       ld_result;
    logic              mis;
    logic              accept, ld_ok, st_ok;
    logic [3:0]        be;
    logic [31:0]       wdat;
    logic              clr_we, clr_done;
    logic [IDX_W-1:0]  clr_idx;
    logic              read_valid_q, misaligned_q;
    logic [31:0]       read_data_q;
    logic              unused_addr;

    // Upper address bits wrap away by design
    assign unused_addr = ^bus.address;
    assign idx         = bus.address[2 +: IDX_W];
    assign lane        = bus.address[LANE_W-1:0];

    assign accept = bus.req && (state_q == S_IDLE);
    assign ld_ok  = accept && !bus.write && !mis;
    assign st_ok  = accept &&  bus.write && !mis;

    dmem_load_align u_load_align (
        .rd_word     (mem[idx]),
        .lane        (lane),
        .size        (bus.size),
        .unsigned_ld (bus.unsigned_ld),
        .result      (ld_result),
        .misaligned  (mis)
    );

    // Store data is replicated across lanes; byte enables pick the target lane(s)
    always_comb begin
        be   = '0;
        wdat = bus.write_data;
        case (size_e'(bus.size))
            SZ_BYTE: begin
                be   = 4'b0001 << lane;
                wdat = {4{bus.write_data[7:0]}};
            end
            SZ_HALF: begin
                be   = lane[1] ? 4'b1100 : 4'b0011;
                wdat = {2{bus.write_data[15:0]}};
            end
            SZ_WORD: be = 4'b1111;
            default: be = '0;
        endcase
    end

`ifdef DMEM_CLEAR_EN
    logic [IDX_W-1:0] clr_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_cnt_q <= '0;
        end else if (state_q == S_INIT) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
        end
    end

    assign clr_we   = (state_q == S_INIT);
    assign clr_idx  = clr_cnt_q;
    assign clr_done = (clr_cnt_q == '1);
`else
    assign clr_we   = 1'b0;
    assign clr_idx  = '0;
    assign clr_done = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_idx] <= '0;
        end else if (st_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdat[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_INIT;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:  if (clr_done) state_d = S_IDLE;
            S_IDLE:  state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_valid_q <= 1'b0;
            read_data_q  <= '0;
            misaligned_q <= 1'b0;
        end else begin
            read_valid_q <= ld_ok;
            misaligned_q <= accept && mis;
            if (ld_ok) read_data_q <= ld_result;
        end
    end

    assign bus.ready      = (state_q == S_IDLE);
    assign bus.read_valid = read_valid_q;
    assign bus.read_data  = read_data_q;
    assign bus.misaligned = misaligned_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed scenarios plus randomized traffic against a byte-lane memory model.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int DEPTH = 64;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    logic [31:0] ref_mem [DEPTH];
    logic        exp_valid;
    logic        exp_mis;
    logic [31:0] exp_data;

    dmem_if #(.ADDR_WIDTH(32)) bus ();

    dmem_ctrl #(.DEPTH(DEPTH), .ADDR_WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

`ifdef DMEM_CLEAR_EN
    localparam int EXP_INIT_EDGES = DEPTH;
`else
    localparam int EXP_INIT_EDGES = 1;
`endif

    function automatic logic [31:0] load_ref(input logic [31:0] w, input int ln,
                                             input logic [1:0] sz, input bit u);
        logic [31:0] v;
        if (sz == SZ_BYTE) begin
            v = (w >> (8 * ln)) & 32'hFF;
            if (!u && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (sz == SZ_HALF) begin
            v = (w >> (8 * ln)) & 32'hFFFF;
            if (!u && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] store_ref(input logic [31:0] w, input int ln,
                                              input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] mask;
        if (sz == SZ_BYTE) begin
            mask = 32'hFF << (8 * ln);
            return (w & ~mask) | ((d & 32'hFF) << (8 * ln));
        end else if (sz == SZ_HALF) begin
            mask = 32'hFFFF << (8 * ln);
            return (w & ~mask) | ((d & 32'hFFFF) << (8 * ln));
        end
        return d;
    endfunction

    // One clock of traffic: drives a request, advances the model, samples #1 after the edge
    task automatic step(input bit r, input bit w, input logic [1:0] sz, input bit u,
                        input logic [31:0] a, input logic [31:0] d);
        int  wi;
        int  ln;
        bit  bad;
        wi  = int'((a >> 2) % DEPTH);
        ln  = int'(a % 4);
        bad = (sz == SZ_RSVD) || (sz == SZ_HALF && (ln % 2) != 0) || (sz == SZ_WORD && ln != 0);
        bus.req         = r;
        bus.write       = w;
        bus.size        = sz;
        bus.unsigned_ld = u;
        bus.address     = a;
        bus.write_data  = d;
        exp_mis   = r && bad;
        exp_valid = r && !w && !bad;
        if (exp_valid) exp_data = load_ref(ref_mem[wi], ln, sz, u);
        if (r && w && !bad) ref_mem[wi] = store_ref(ref_mem[wi], ln, sz, d);
        @(posedge clk);
        #1;
        bus.req = 1'b0;
    endtask

    task automatic test_reset;
        int n;
        reset_n = 1'b0;
        bus.req = 1'b0; bus.write = 1'b0; bus.size = SZ_WORD; bus.unsigned_ld = 1'b0;
        bus.address = '0; bus.write_data = '0;
        exp_data = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", bus.ready); end
        n_cmp++; if (bus.read_valid !== 1'b0) begin n_err++; $display("FAIL reset_read_valid: got %b want 0", bus.read_valid); end
        n_cmp++; if (bus.read_data !== 32'h0) begin n_err++; $display("FAIL reset_read_data: got %h want 0", bus.read_data); end
        n_cmp++; if (bus.misaligned !== 1'b0) begin n_err++; $display("FAIL reset_misaligned: got %b want 0", bus.misaligned); end
        reset_n = 1'b1;
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.ready === 1'b1) break;
        end
        n_cmp++;
        if (n !== EXP_INIT_EDGES) begin
            n_err++; $display("FAIL ready_rise: got %0d edges want %0d", n, EXP_INIT_EDGES);
        end
`ifdef DMEM_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        step(1, 0, SZ_WORD, 0, 32'd20, 32'h0);
        n_cmp++; if (bus.read_valid !== 1'b1) begin n_err++; $display("FAIL clear_load_valid: got %b want 1", bus.read_valid); end
        n_cmp++; if (bus.read_data !== 32'h0) begin n_err++; $display("FAIL clear_load_data: got %h want 0", bus.read_data); end
`endif
    endtask

    task automatic test_fill;
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 1, SZ_WORD, 0, 32'(i * 4), $urandom);
            n_cmp++;
            if (bus.read_valid !== 1'b0 || bus.misaligned !== 1'b0) begin
                n_err++; $display("FAIL fill_store %0d: valid=%b mis=%b want 0/0", i, bus.read_valid, bus.misaligned);
            end
        end
    endtask

    task automatic test_word_and_partial;
        step(1, 1, SZ_WORD, 0, 32'd12, 32'hDEADBEEF);
        step(1, 0, SZ_WORD, 0, 32'd12, 32'h0);
        n_cmp++; if (bus.read_valid !== 1'b1 || bus.read_data !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL word_load: valid=%b data=%h want 1/deadbeef", bus.read_valid, bus.read_data); end
        step(1, 0, SZ_BYTE, 0, 32'd13, 32'h0);
        n_cmp++; if (bus.read_data !== 32'hFFFFFFBE) begin
            n_err++; $display("FAIL byte_signed: got %h want ffffffbe", bus.read_data); end
        step(1, 0, SZ_BYTE, 1, 32'd13, 32'h0);
        n_cmp++; if (bus.read_data !== 32'h000000BE) begin
            n_err++; $display("FAIL byte_unsigned: got %h want 000000be", bus.read_data); end
        step(1, 0, SZ_HALF, 0, 32'd14, 32'h0);
        n_cmp++; if (bus.read_data !== 32'hFFFFDEAD) begin
            n_err++; $display("FAIL half_signed: got %h want ffffdead", bus.read_data); end
        step(1, 1, SZ_BYTE, 0, 32'd12, 32'hFFFFFF11);
        step(1, 1, SZ_HALF, 0, 32'd14, 32'hFFFF2233);
        step(1, 0, SZ_WORD, 0, 32'd12, 32'h0);
        n_cmp++; if (bus.read_data !== 32'h2233BE11) begin
            n_err++; $display("FAIL partial_merge: got %h want 2233be11", bus.read_data); end
        step(0, 0, SZ_WORD, 0, 32'd0, 32'h0);
        n_cmp++; if (bus.read_valid !== 1'b0 || bus.read_data !== 32'h2233BE11) begin
            n_err++; $display("FAIL valid_drop_hold: valid=%b data=%h want 0/2233be11", bus.read_valid, bus.read_data); end
    endtask

    task automatic test_misalign;
        step(1, 1, SZ_WORD, 0, 32'd14, 32'hCAFEF00D);
        n_cmp++; if (bus.misaligned !== 1'b1 || bus.read_valid !== 1'b0) begin
            n_err++; $display("FAIL mis_store: mis=%b valid=%b want 1/0", bus.misaligned, bus.read_valid); end
        step(0, 0, SZ_WORD, 0, 32'd0, 32'h0);
        n_cmp++; if (bus.misaligned !== 1'b0) begin
            n_err++; $display("FAIL mis_pulse_width: got %b want 0", bus.misaligned); end
        step(1, 0, SZ_WORD, 0, 32'd12, 32'h0);
        n_cmp++; if (bus.read_data !== 32'h2233BE11) begin
            n_err++; $display("FAIL mis_store_no_write: got %h want 2233be11", bus.read_data); end
        step(1, 0, SZ_HALF, 0, 32'd13, 32'h0);
        n_cmp++; if (bus.misaligned !== 1'b1 || bus.read_valid !== 1'b0 || bus.read_data !== 32'h2233BE11) begin
            n_err++; $display("FAIL mis_load: mis=%b valid=%b data=%h want 1/0/2233be11",
                              bus.misaligned, bus.read_valid, bus.read_data); end
        step(1, 0, SZ_RSVD, 0, 32'd12, 32'h0);
        n_cmp++; if (bus.misaligned !== 1'b1 || bus.read_valid !== 1'b0) begin
            n_err++; $display("FAIL mis_reserved: mis=%b valid=%b want 1/0", bus.misaligned, bus.read_valid); end
    endtask

    task automatic test_random;
        bit          r, w, u;
        logic [1:0]  sz;
        logic [31:0] a;
        for (int i = 0; i < 500; i++) begin
            r  = ($urandom_range(0, 3) != 0);
            w  = $urandom_range(0, 1) == 1;
            u  = $urandom_range(0, 1) == 1;
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == SZ_WORD) a[1:0] = 2'b00;
                else if (sz == SZ_HALF) a[0] = 1'b0;
            end
            n_cmp++; if (bus.ready !== 1'b1) begin
                n_err++; $display("FAIL rand_ready %0d: got %b want 1", i, bus.ready); end
            step(r, w, sz, u, a, $urandom);
            n_cmp++;
            if (bus.read_valid !== exp_valid || bus.misaligned !== exp_mis || bus.read_data !== exp_data) begin
                n_err++;
                $display("FAIL rand_access %0d: valid=%b mis=%b data=%h want %b/%b/%h",
                         i, bus.read_valid, bus.misaligned, bus.read_data, exp_valid, exp_mis, exp_data);
            end
        end
    endtask

    task automatic test_reset_mid_clear;
        int n;
        reset_n  = 1'b0;
        exp_data = '0;
        #1;
        n_cmp++; if (bus.read_data !== 32'h0 || bus.ready !== 1'b0) begin
            n_err++; $display("FAIL rerun_reset: data=%h ready=%b want 0/0", bus.read_data, bus.ready); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
`ifdef DMEM_CLEAR_EN
        repeat (30) @(posedge clk);
        #1;
        n_cmp++; if (bus.ready !== 1'b0) begin
            n_err++; $display("FAIL mid_clear_ready: got %b want 0", bus.ready); end
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`endif
        // A store offered while not ready must leave no trace
        bus.req = 1'b1; bus.write = 1'b1; bus.size = SZ_WORD;
        bus.address = 32'd20; bus.write_data = 32'h5A5A5A5A;
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.ready === 1'b1) break;
        end
        bus.req = 1'b0;
        n_cmp++;
        if (n !== EXP_INIT_EDGES) begin
            n_err++; $display("FAIL rerun_ready_rise: got %0d edges want %0d", n, EXP_INIT_EDGES);
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 0, SZ_WORD, 0, 32'(i * 4), 32'h0);
            n_cmp++;
            if (bus.read_valid !== 1'b1 || bus.read_data !== exp_data) begin
                n_err++; $display("FAIL readback word %0d: valid=%b data=%h want 1/%h",
                                  i, bus.read_valid, bus.read_data, exp_data);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_fill();
        test_word_and_partial();
        test_misalign();
        test_random();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
